// File: rtl/conv_mac_engine_pkg.sv
// Shared types and helpers for the convolution engine and its window-buffer peer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_RDY,
        REQ,
        MAC,
        DRAIN,
        WRITE,
        ADV
    } conv_state_t;

    // Count direction shared with the window buffer's walkers.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int acc_width(input int pixel_depth, input int coef_depth,
                                     input int max_kernel);
        return pixel_depth + coef_depth + 2 * $clog2(max_kernel);
    endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// Window handshake, coefficient SRAM port and output SRAM port of the engine.
interface conv_mac_engine_if #(
    parameter int MAX_KERNEL  = 31,
    parameter int X_MAX       = 60,
    parameter int Y_MAX       = 60,
    parameter int PIXEL_DEPTH = 8,
    parameter int COEF_DEPTH  = 8
);
    logic                                                 new_sample_req;
    logic                                                 new_sample_ready;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIXEL_DEPTH-1:0] working_memory;
    logic [$clog2(MAX_KERNEL)-1:0]                        coef_x;
    logic [$clog2(MAX_KERNEL)-1:0]                        coef_y;
    logic                                                 coef_ren;
    logic [COEF_DEPTH-1:0]                                coef_rdat;
    logic                                                 out_wen;
    logic [$clog2(X_MAX):0]                               out_x;
    logic [$clog2(Y_MAX):0]                               out_y;
    logic [PIXEL_DEPTH-1:0]                               out_wdat;

    modport master (
        output new_sample_req, coef_x, coef_y, coef_ren, out_wen, out_x, out_y, out_wdat,
        input  new_sample_ready, working_memory, coef_rdat
    );

    modport slave (
        input  new_sample_req, coef_x, coef_y, coef_ren, out_wen, out_x, out_y, out_wdat,
        output new_sample_ready, working_memory, coef_rdat
    );
endinterface

// File: rtl/conv_mac_engine_mac_unit.sv
// Multiply-accumulate with the window index delayed one cycle to meet the coefficient read data.
module mac_unit #(
    parameter int MAX_KERNEL = 31,
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 8,
    parameter int ACC_W      = 26
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic                                       clear,
    input  logic                                       en,
    input  logic [$clog2(MAX_KERNEL)-1:0]              idx_x,
    input  logic [$clog2(MAX_KERNEL)-1:0]              idx_y,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][DATA_W-1:0] window,
    input  logic [COEF_W-1:0]                          coef,
    output logic [ACC_W-1:0]                           acc
);
    logic [$clog2(MAX_KERNEL)-1:0] idx_x_p1;
    logic [$clog2(MAX_KERNEL)-1:0] idx_y_p1;
    logic                          vld_p1;
    logic [DATA_W-1:0]             pix_p1;
    logic [DATA_W+COEF_W-1:0]      prod_p1;

    // stage p1: index aligned with the coefficient returned by the SRAM
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) vld_p1 <= 1'b0;
        else        vld_p1 <= en;
    end

    always_ff @(posedge clk) begin
        idx_x_p1 <= idx_x;
        idx_y_p1 <= idx_y;
    end

    assign pix_p1  = window[idx_x_p1][idx_y_p1];
    assign prod_p1 = pix_p1 * coef;

    // stage p2: accumulator, wide enough that a full window never wraps
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      acc <= '0;
        else if (clear)  acc <= '0;
        else if (vld_p1) acc <= acc + ACC_W'(prod_p1);
    end
endmodule

// File: rtl/flex_counter_dir.sv
// Wrapping up/down counter with programmable rollover value and a terminal flag.
module flex_counter_dir
    import conv_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    dir,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);
    logic [NUM_CNT_BITS-1:0] next_count;

    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (dir == DIR_UP)
                next_count = (count_out == rollover_val) ? '0 : count_out + NUM_CNT_BITS'(1);
            else
                next_count = (count_out == '0) ? rollover_val : count_out - NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_out <= '0;
        else        count_out <= next_count;
    end

    assign rollover_flag = (dir == DIR_UP) ? (count_out == rollover_val) : (count_out == '0);
endmodule

// File: rtl/conv_mac_engine.sv
// Convolution engine: fetches a window, runs a k*k MAC against the kernel SRAM, writes one pixel.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int MAX_KERNEL  = 31,
    parameter int X_MAX       = 60,
    parameter int Y_MAX       = 60,
    parameter int PIXEL_DEPTH = 8,
    parameter int COEF_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic [$clog2(MAX_KERNEL)-1:0] kernel_size,
    input  logic [4:0]                    norm_shift,
    output logic                          new_trans,
    input  logic [$clog2(X_MAX)-1:0]      curr_x,
    input  logic [$clog2(Y_MAX)-1:0]      curr_y,
    input  logic                          end_pos,
    output logic                          update_pos,
    output logic                          busy,
    output logic                          done,
    conv_mac_engine_if.master             bus
);
    localparam int KW    = $clog2(MAX_KERNEL);
    localparam int ACC_W = acc_width(PIXEL_DEPTH, COEF_DEPTH, MAX_KERNEL);

    conv_state_t       state, next_state;
    logic [KW-1:0]     k_m1;
    logic [4:0]        shift_r;
    logic [KW-1:0]     cnt_x, cnt_y;
    logic              x_last, y_last;
    logic              st_req, st_mac, st_write, st_adv;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_shifted;

    function automatic logic [PIXEL_DEPTH-1:0] sat_pix(input logic [ACC_W-1:0] v);
        if (|v[ACC_W-1:PIXEL_DEPTH]) return '1;
        return v[PIXEL_DEPTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            k_m1    <= '0;
            shift_r <= '0;
        end else begin
            state <= next_state;
            // kernel_size 0 behaves as a 1x1 kernel
            if (state == IDLE && start) begin
                k_m1    <= (kernel_size == '0) ? '0 : kernel_size - KW'(1);
                shift_r <= norm_shift;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = INIT;
            INIT:     next_state = WAIT_RDY;
            WAIT_RDY: if (bus.new_sample_ready) next_state = REQ;
            REQ:      next_state = MAC;
            MAC:      if (x_last && y_last) next_state = DRAIN;
            DRAIN:    next_state = WRITE;
            WRITE:    next_state = ADV;
            ADV:      next_state = end_pos ? IDLE : WAIT_RDY;
            default:  next_state = IDLE;
        endcase
    end

    assign st_req   = (state == REQ);
    assign st_mac   = (state == MAC);
    assign st_write = (state == WRITE);
    assign st_adv   = (state == ADV);

    // x walks inner, y outer
    flex_counter_dir #(.NUM_CNT_BITS(KW)) u_cnt_x (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (st_req),
        .count_enable (st_mac),
        .dir          (DIR_UP),
        .rollover_val (k_m1),
        .count_out    (cnt_x),
        .rollover_flag(x_last)
    );

    flex_counter_dir #(.NUM_CNT_BITS(KW)) u_cnt_y (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (st_req),
        .count_enable (st_mac && x_last),
        .dir          (DIR_UP),
        .rollover_val (k_m1),
        .count_out    (cnt_y),
        .rollover_flag(y_last)
    );

    mac_unit #(
        .MAX_KERNEL(MAX_KERNEL),
        .DATA_W    (PIXEL_DEPTH),
        .COEF_W    (COEF_DEPTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (st_req),
        .en    (st_mac),
        .idx_x (cnt_x),
        .idx_y (cnt_y),
        .window(bus.working_memory),
        .coef  (bus.coef_rdat),
        .acc   (acc)
    );

    assign acc_shifted = acc >> shift_r;

    assign new_trans          = (state == INIT);
    assign busy               = (state != IDLE);
    assign update_pos         = st_adv && !end_pos;
    assign done               = st_adv && end_pos;
    assign bus.new_sample_req = st_req;
    assign bus.coef_ren       = st_mac;
    assign bus.coef_x         = st_mac ? cnt_x : '0;
    assign bus.coef_y         = st_mac ? cnt_y : '0;
    assign bus.out_wen        = st_write;
    assign bus.out_x          = st_write ? {1'b0, curr_x} : '0;
    assign bus.out_y          = st_write ? {1'b0, curr_y} : '0;
    assign bus.out_wdat       = st_write ? sat_pix(acc_shifted) : '0;
endmodule
